// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 captures the request, S2 computes and holds the result.
// A registered N/V/Z flag file is updated on the output handshake.

module alu_pipe_lane #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);
  logic [LANE_W-1:0] sum;
  logic              ovf;

  assign sum = a + b;
  assign ovf = (a[LANE_W-1] == b[LANE_W-1]) && (sum[LANE_W-1] != a[LANE_W-1]);
  assign y   = !ovf ? sum :
               a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
endmodule

module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       res_op,
  output logic [2:0]       flags
);
  localparam int STAGES = 2;
  localparam int SH_W   = $clog2(WIDTH);
  localparam int NLANE  = WIDTH / LANE_W;
  localparam int NBYTE  = WIDTH / 8;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_RED = 4'h2, OP_XOR = 4'h3,
                         OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PAD = 4'h7,
                         OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  req_t              s1_q;
  logic [STAGES:1]   vld_pipe;
  logic              adv;
  logic              s2_v;

  assign adv       = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || adv;
  assign out_valid = vld_pipe[2];

  // ---------------- S2 compute ----------------
  logic [WIDTH-1:0]   a, b;
  logic [SH_W-1:0]    amt;
  logic [WIDTH-1:0]   sum_add, sum_sub, sat_val, red_sum, lw_addr;
  logic [2*WIDTH-1:0] rot2;
  logic               v_add, v_sub;
  logic [WIDTH-1:0]   res_c;
  logic               v_c;

  logic [NLANE-1:0][LANE_W-1:0] lane_a, lane_b, lane_y;

  assign a   = s1_q.a;
  assign b   = s1_q.b;
  assign amt = b[SH_W-1:0];

  assign sum_add = a + b;
  assign sum_sub = a - b;
  assign v_add   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
  assign v_sub   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
  // overflow direction always follows the sign of op_a for both ADD and SUB
  assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign rot2    = {a, a} >> amt;
  assign lw_addr = (a & ~WIDTH'(1)) + (b << 1);

  assign lane_a = a;
  assign lane_b = b;

  genvar gl;
  generate
    for (gl = 0; gl < NLANE; gl++) begin : g_lane
      alu_pipe_lane #(.LANE_W(LANE_W)) u_lane (
        .a (lane_a[gl]),
        .b (lane_b[gl]),
        .y (lane_y[gl])
      );
    end
  endgenerate

  // byte sum cannot exceed WIDTH bits for WIDTH >= 16, so no clamp is needed
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NBYTE; i++) begin
      red_sum = red_sum + {{(WIDTH-8){a[8*i+7]}}, a[8*i +: 8]}
                        + {{(WIDTH-8){b[8*i+7]}}, b[8*i +: 8]};
    end
  end

  always_comb begin
    res_c = '0;
    v_c   = 1'b0;
    case (s1_q.op)
      OP_ADD: begin
        v_c   = v_add;
        res_c = (SAT != 0 && v_add) ? sat_val : sum_add;
      end
      OP_SUB: begin
        v_c   = v_sub;
        res_c = (SAT != 0 && v_sub) ? sat_val : sum_sub;
      end
      OP_RED:        res_c = red_sum;
      OP_XOR:        res_c = a ^ b;
      OP_SLL:        res_c = a << amt;
      OP_SRA:        res_c = $signed(a) >>> amt;
      OP_ROR:        res_c = rot2[WIDTH-1:0];
      OP_PAD:        res_c = lane_y;
      OP_LW, OP_SW:  res_c = lw_addr;
      OP_LHB:        res_c = {b[7:0], a[WIDTH-9:0]};
      OP_LLB:        res_c = {a[WIDTH-1:8], b[7:0]};
      default:       res_c = '0;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      result   <= '0;
      res_op   <= '0;
      s2_v     <= 1'b0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= '{op: opcode, a: op_a, b: op_b};
      end
      if (adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          result <= res_c;
          res_op <= s1_q.op;
          s2_v   <= v_c;
        end
      end
    end
  end

  // ---------------- flag file {N,V,Z} ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (out_valid && out_ready) begin
      case (res_op)
        OP_ADD, OP_SUB:                 flags <= {result[WIDTH-1], s2_v, result == '0};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags <= {flags[2:1], result == '0};
        default:                        flags <= flags;
      endcase
    end
  end
endmodule
